// File: rtl/sram_arb_pkg.sv
// rtl/sram_arb_pkg.sv - shared types and default widths for the SRAM arbiter
package sram_arb_pkg;

    localparam int ADDR_W_DEF = 20;
    localparam int DATA_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        TURN  = 2'd3
    } state_t;

    typedef enum logic {
        OWN_VID  = 1'b0,
        OWN_HOST = 1'b1
    } owner_t;

endpackage

// File: rtl/sram_arb_priority.sv
// rtl/sram_arb_priority.sv - fixed video priority with host starvation guard
module sram_arb_priority
    import sram_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic vid_req,
    input  logic host_req,
    input  logic arb_en,
    output logic gnt_vid,
    output logic gnt_host
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    logic [CW-1:0] starve_cnt;
    logic          host_forced;

    // Video wins by default; host is forced in once video has had LIMIT grants while host waited
    always_comb begin
        host_forced = host_req && (starve_cnt == LIMIT);
        gnt_vid     = arb_en && vid_req && !host_forced;
        gnt_host    = arb_en && host_req && (!vid_req || host_forced);
    end

    // Count video grants taken while the host is waiting; any host grant clears the count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (gnt_host) begin
            starve_cnt <= '0;
        end else if (gnt_vid && host_req && (starve_cnt != LIMIT)) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - two-port async SRAM arbiter (optional stats: SRAM_ARB_STATS_EN)
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W        = ADDR_W_DEF,
    parameter int DATA_W        = DATA_W_DEF,
    parameter int ACCESS_CYCLES = 2,
    parameter int STARVE_LIMIT  = 8
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_ack,
    output logic [DATA_W-1:0] vid_rdata,
    output logic              vid_rvalid,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    input  logic [1:0]        host_be,
    output logic              host_ack,
    output logic [DATA_W-1:0] host_rdata,
    output logic              host_rvalid,
    inout  wire  [DATA_W-1:0] sram_DQ,
    output logic [ADDR_W-1:0] sram_ADDR,
    output logic              sram_LB_N,
    output logic              sram_UB_N,
    output logic              sram_CE_N,
    output logic              sram_OE_N,
    output logic              sram_WE_N
`ifdef SRAM_ARB_STATS_EN
    ,
    output logic [31:0]       stat_vid_grants,
    output logic [31:0]       stat_host_grants,
    output logic [15:0]       stat_max_host_wait
`endif
);

    localparam int CNT_W = $clog2(ACCESS_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACCESS_CYCLES - 1);

    state_t            state;
    state_t            next_state;
    owner_t            owner;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [1:0]        be_q;
    logic              last_cycle;
    logic              arb_en;
    logic              gnt_vid;
    logic              gnt_host;
    logic              dq_oe;

    assign last_cycle = (cnt == '0);
    // Arbitration is held off while reset is asserted so no ack can leak out during reset
    assign arb_en = reset_reset_n && ((state == IDLE) || ((state == READ) && last_cycle));

    sram_arb_priority #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_priority (
        .clk     (clk_clk),
        .rst_n   (reset_reset_n),
        .vid_req (vid_req),
        .host_req(host_req),
        .arb_en  (arb_en),
        .gnt_vid (gnt_vid),
        .gnt_host(gnt_host)
    );

    // State register
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state, grant acks and SRAM strobes decoded from the current state
    always_comb begin
        next_state = state;
        vid_ack    = gnt_vid;
        host_ack   = gnt_host;
        sram_CE_N  = 1'b1;
        sram_OE_N  = 1'b1;
        sram_WE_N  = 1'b1;
        sram_LB_N  = 1'b1;
        sram_UB_N  = 1'b1;
        dq_oe      = 1'b0;
        unique case (state)
            IDLE: begin
                if (gnt_vid || gnt_host) begin
                    next_state = (gnt_host && host_we) ? WRITE : READ;
                end
            end
            READ: begin
                sram_CE_N = 1'b0;
                sram_OE_N = 1'b0;
                sram_LB_N = 1'b0;
                sram_UB_N = 1'b0;
                if (last_cycle) begin
                    if (gnt_vid || gnt_host) begin
                        next_state = (gnt_host && host_we) ? WRITE : READ;
                    end else begin
                        next_state = IDLE;
                    end
                end
            end
            WRITE: begin
                sram_CE_N = 1'b0;
                sram_WE_N = (be_q == 2'b00);
                sram_LB_N = ~be_q[0];
                sram_UB_N = ~be_q[1];
                dq_oe     = 1'b1;
                if (last_cycle) begin
                    next_state = TURN;
                end
            end
            TURN: begin
                sram_CE_N  = 1'b0;
                sram_LB_N  = ~be_q[0];
                sram_UB_N  = ~be_q[1];
                dq_oe      = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Latch the granted request and run the per-access strobe counter
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            owner   <= OWN_VID;
            cnt     <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= 2'b00;
        end else if (gnt_vid) begin
            owner  <= OWN_VID;
            addr_q <= vid_addr;
            cnt    <= CNT_LOAD;
        end else if (gnt_host) begin
            owner   <= OWN_HOST;
            addr_q  <= host_addr;
            wdata_q <= host_wdata;
            be_q    <= host_be;
            cnt     <= CNT_LOAD;
        end else if (((state == READ) || (state == WRITE)) && !last_cycle) begin
            cnt <= cnt - 1'b1;
        end
    end

    // Capture read data at the edge closing the strobe and steer it to the owner
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            vid_rdata   <= '0;
            host_rdata  <= '0;
            vid_rvalid  <= 1'b0;
            host_rvalid <= 1'b0;
        end else begin
            vid_rvalid  <= 1'b0;
            host_rvalid <= 1'b0;
            if ((state == READ) && last_cycle) begin
                if (owner == OWN_VID) begin
                    vid_rdata  <= sram_DQ;
                    vid_rvalid <= 1'b1;
                end else begin
                    host_rdata  <= sram_DQ;
                    host_rvalid <= 1'b1;
                end
            end
        end
    end

    assign sram_ADDR = addr_q;
    assign sram_DQ   = dq_oe ? wdata_q : {DATA_W{1'bz}};

`ifdef SRAM_ARB_STATS_EN
    logic [15:0] wait_cnt;

    // Grant counters wrap; host wait is measured in cycles of host_req before its ack
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            stat_vid_grants    <= '0;
            stat_host_grants   <= '0;
            stat_max_host_wait <= '0;
            wait_cnt           <= '0;
        end else begin
            if (gnt_vid) begin
                stat_vid_grants <= stat_vid_grants + 32'd1;
            end
            if (gnt_host) begin
                stat_host_grants <= stat_host_grants + 32'd1;
                if (wait_cnt > stat_max_host_wait) begin
                    stat_max_host_wait <= wait_cnt;
                end
                wait_cnt <= '0;
            end else if (host_req && (wait_cnt != 16'hFFFF)) begin
                wait_cnt <= wait_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - directed vector bench for sram_arbiter with async SRAM model
module tb_sram_arbiter;

    logic        clk_clk;
    logic        reset_reset_n;
    logic        vid_req;
    logic [19:0] vid_addr;
    logic        vid_ack;
    logic [15:0] vid_rdata;
    logic        vid_rvalid;
    logic        host_req;
    logic        host_we;
    logic [19:0] host_addr;
    logic [15:0] host_wdata;
    logic [1:0]  host_be;
    logic        host_ack;
    logic [15:0] host_rdata;
    logic        host_rvalid;
    wire  [15:0] sram_DQ;
    logic [19:0] sram_ADDR;
    logic        sram_LB_N;
    logic        sram_UB_N;
    logic        sram_CE_N;
    logic        sram_OE_N;
    logic        sram_WE_N;

    int errors = 0;
    int checks = 0;
    int overlap_cnt = 0;
    int dual_ack_cnt = 0;

    logic [15:0] mem [0:255];

    sram_arbiter dut (
        .clk_clk      (clk_clk),
        .reset_reset_n(reset_reset_n),
        .vid_req      (vid_req),
        .vid_addr     (vid_addr),
        .vid_ack      (vid_ack),
        .vid_rdata    (vid_rdata),
        .vid_rvalid   (vid_rvalid),
        .host_req     (host_req),
        .host_we      (host_we),
        .host_addr    (host_addr),
        .host_wdata   (host_wdata),
        .host_be      (host_be),
        .host_ack     (host_ack),
        .host_rdata   (host_rdata),
        .host_rvalid  (host_rvalid),
        .sram_DQ      (sram_DQ),
        .sram_ADDR    (sram_ADDR),
        .sram_LB_N    (sram_LB_N),
        .sram_UB_N    (sram_UB_N),
        .sram_CE_N    (sram_CE_N),
        .sram_OE_N    (sram_OE_N),
        .sram_WE_N    (sram_WE_N)
    );

    initial clk_clk = 1'b0;
    always #5 clk_clk = ~clk_clk;

    // SRAM model: drives DQ while read-enabled, byte-lane writes while WE_N is low
    assign sram_DQ = (!sram_CE_N && !sram_OE_N && sram_WE_N) ? mem[sram_ADDR[7:0]] : 16'hzzzz;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'(i);
        for (int i = 0; i < 4; i++) mem[i] = 16'hA000 + 16'(i);
        mem[8'h10] = 16'hBEEF;
        mem[8'hFF] = 16'hAB00;
        mem[8'h20] = 16'h1111;
        forever begin
            @(posedge clk_clk);
            if (!sram_CE_N && !sram_WE_N) begin
                if (!sram_LB_N) mem[sram_ADDR[7:0]][7:0]  = sram_DQ[7:0];
                if (!sram_UB_N) mem[sram_ADDR[7:0]][15:8] = sram_DQ[15:8];
            end
        end
    end

    always @(negedge clk_clk) begin
        if (reset_reset_n && !sram_OE_N && !sram_WE_N) overlap_cnt++;
        if (reset_reset_n && vid_ack && host_ack) dual_ack_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        bit          vid;
        bit          we;
        logic [19:0] addr;
        logic [15:0] wdata;
        logic [1:0]  be;
        int          e_oe;
        int          e_we;
        int          e_ce;
        logic        e_lb;
        logic        e_ub;
        int          e_rv;
        logic [15:0] e_data;
    } vec_t;

    vec_t vecs[9];

    // One isolated transaction from IDLE; e_data is read data for reads, TURN-cycle DQ for writes
    task automatic run_vec(input int idx, input vec_t v);
        int ack_k, oe_cnt, we_cnt, ce_cnt, rv_k, wrong_rv;
        logic lb1, ub1;
        logic [15:0] rd, dq3;
        ack_k = -1; oe_cnt = 0; we_cnt = 0; ce_cnt = 0; rv_k = 0; wrong_rv = 0;
        lb1 = 1'b1; ub1 = 1'b1; rd = '0; dq3 = '0;
        @(posedge clk_clk); #1;
        if (v.vid) begin
            vid_req = 1'b1; vid_addr = v.addr;
        end else begin
            host_req = 1'b1; host_we = v.we; host_addr = v.addr;
            host_wdata = v.wdata; host_be = v.be;
        end
        for (int i = 0; i < 10 && ack_k < 0; i++) begin
            @(negedge clk_clk);
            if (v.vid ? vid_ack : host_ack) ack_k = i;
        end
        check($sformatf("vec%0d_ack", idx), ack_k, 0);
        @(posedge clk_clk); #1;
        vid_req = 1'b0; host_req = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk_clk);
            if (!sram_OE_N) oe_cnt++;
            if (!sram_WE_N) we_cnt++;
            if (!sram_CE_N) ce_cnt++;
            if (k == 1) begin lb1 = sram_LB_N; ub1 = sram_UB_N; end
            if (k == 3) dq3 = sram_DQ;
            if (v.vid ? vid_rvalid : host_rvalid) begin rv_k = k; rd = v.vid ? vid_rdata : host_rdata; end
            if (v.vid ? host_rvalid : vid_rvalid) wrong_rv++;
        end
        check($sformatf("vec%0d_oe_cycles", idx), oe_cnt, v.e_oe);
        check($sformatf("vec%0d_we_cycles", idx), we_cnt, v.e_we);
        check($sformatf("vec%0d_ce_cycles", idx), ce_cnt, v.e_ce);
        check($sformatf("vec%0d_lb_n", idx), lb1, v.e_lb);
        check($sformatf("vec%0d_ub_n", idx), ub1, v.e_ub);
        check($sformatf("vec%0d_rvalid_cycle", idx), rv_k, v.e_rv);
        check($sformatf("vec%0d_other_rvalid", idx), wrong_rv, 0);
        if (v.we) check($sformatf("vec%0d_turn_dq", idx), dq3, v.e_data);
        else      check($sformatf("vec%0d_rdata", idx), rd, v.e_data);
    endtask

    initial begin
        int ack_cyc[4];
        int n_ack, n_rv, oe_hi, rounds, vcount, vack_k, oe_low_k, acks_after, rv_after;
        int counts[2];
        bit got_ack;
        bit dq4_drv;
        logic [15:0] got[4];
        logic [15:0] rd;

        reset_reset_n = 1'b0;
        vid_req = 1'b0; vid_addr = '0;
        host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0; host_be = 2'b00;

        vecs[0] = '{1'b1, 1'b0, 20'h00010, 16'h0000, 2'b11, 2, 0, 2, 1'b0, 1'b0, 3, 16'hBEEF};
        vecs[1] = '{1'b0, 1'b1, 20'hFFFFF, 16'h1234, 2'b01, 0, 2, 3, 1'b0, 1'b1, 0, 16'h1234};
        vecs[2] = '{1'b0, 1'b0, 20'hFFFFF, 16'h0000, 2'b11, 2, 0, 2, 1'b0, 1'b0, 3, 16'hAB34};
        vecs[3] = '{1'b0, 1'b1, 20'h00020, 16'h5678, 2'b10, 0, 2, 3, 1'b1, 1'b0, 0, 16'h5678};
        vecs[4] = '{1'b0, 1'b0, 20'h00020, 16'h0000, 2'b11, 2, 0, 2, 1'b0, 1'b0, 3, 16'h5611};
        vecs[5] = '{1'b0, 1'b1, 20'h00020, 16'hFFFF, 2'b00, 0, 0, 3, 1'b1, 1'b1, 0, 16'hFFFF};
        vecs[6] = '{1'b1, 1'b0, 20'h00020, 16'h0000, 2'b11, 2, 0, 2, 1'b0, 1'b0, 3, 16'h5611};
        vecs[7] = '{1'b0, 1'b1, 20'h00030, 16'hCAFE, 2'b11, 0, 2, 3, 1'b0, 1'b0, 0, 16'hCAFE};
        vecs[8] = '{1'b0, 1'b0, 20'h00030, 16'h0000, 2'b11, 2, 0, 2, 1'b0, 1'b0, 3, 16'hCAFE};

        // Reset state
        #2;
        check("rst_pins", {sram_CE_N, sram_OE_N, sram_WE_N, sram_LB_N, sram_UB_N}, 5'b11111);
        check("rst_addr", sram_ADDR, 0);
        check("rst_acks", {vid_ack, host_ack, vid_rvalid, host_rvalid}, 4'b0000);
        check("rst_rdata", {vid_rdata, host_rdata}, 0);
        repeat (2) @(posedge clk_clk);
        #1 reset_reset_n = 1'b1;

        for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);
        check("hold_vid_rdata", vid_rdata, 16'h5611);
        check("hold_host_rdata", host_rdata, 16'hCAFE);

        // Back-to-back video reads at 0..3
        n_ack = 0; n_rv = 0; oe_hi = 0;
        @(posedge clk_clk); #1;
        vid_req = 1'b1; vid_addr = 20'd0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk_clk);
            if (vid_rvalid) begin
                if (n_rv < 4) got[n_rv] = vid_rdata;
                n_rv++;
            end
            if (n_ack >= 1 && n_rv < 4 && sram_OE_N) oe_hi++;
            got_ack = vid_ack;
            if (vid_ack) begin
                if (n_ack < 4) ack_cyc[n_ack] = c;
                n_ack++;
            end
            @(posedge clk_clk); #1;
            if (got_ack) begin
                if (n_ack < 4) vid_addr = 20'(n_ack);
                else vid_req = 1'b0;
            end
        end
        check("b2b_acks", n_ack, 4);
        check("b2b_rvalids", n_rv, 4);
        check("b2b_oe_gap", oe_hi, 0);
        for (int i = 1; i < 4; i++) check($sformatf("b2b_ack_spacing%0d", i), ack_cyc[i] - ack_cyc[0], 2 * i);
        for (int i = 0; i < 4; i++) check($sformatf("b2b_rdata%0d", i), got[i], 16'hA000 + 16'(i));

        // Starvation: video held, host must get in after exactly STARVE_LIMIT video grants, twice
        rounds = 0; vcount = 0; counts[0] = -1; counts[1] = -1;
        @(posedge clk_clk); #1;
        vid_req = 1'b1; vid_addr = 20'd1;
        host_req = 1'b1; host_we = 1'b0; host_addr = 20'h00010;
        for (int c = 0; c < 150 && rounds < 2; c++) begin
            @(negedge clk_clk);
            if (vid_ack && host_req) vcount++;
            if (host_ack) begin
                counts[rounds] = vcount;
                vcount = 0;
                rounds++;
            end
            @(posedge clk_clk); #1;
            if (rounds == 2) host_req = 1'b0;
        end
        vid_req = 1'b0; host_req = 1'b0;
        repeat (6) @(posedge clk_clk);
        check("starve_rounds", rounds, 2);
        check("starve_round1", counts[0], 8);
        check("starve_round2_after_clear", counts[1], 8);

        // Write immediately followed by a pending video read
        vack_k = -1; oe_low_k = -1; dq4_drv = 1'b1; rd = '0;
        @(posedge clk_clk); #1;
        host_req = 1'b1; host_we = 1'b1; host_addr = 20'h00050; host_wdata = 16'h7777; host_be = 2'b11;
        @(negedge clk_clk);
        check("wtv_host_ack", host_ack, 1'b1);
        @(posedge clk_clk); #1;
        host_req = 1'b0; vid_req = 1'b1; vid_addr = 20'h00050;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk_clk);
            got_ack = vid_ack;
            if (vid_ack && vack_k < 0) vack_k = k;
            if (!sram_OE_N && oe_low_k < 0) oe_low_k = k;
            if (k == 4) dq4_drv = (sram_DQ === 16'h7777);
            if (vid_rvalid) rd = vid_rdata;
            @(posedge clk_clk); #1;
            if (got_ack) vid_req = 1'b0;
        end
        check("wtv_vid_ack_cycle", vack_k, 4);
        check("wtv_first_oe_low", oe_low_k, 5);
        check("wtv_dq_released", dq4_drv, 1'b0);
        check("wtv_readback", rd, 16'h7777);

        // Reset during WRITE cycle 1
        @(posedge clk_clk); #1;
        host_req = 1'b1; host_we = 1'b1; host_addr = 20'h00040; host_wdata = 16'h9999; host_be = 2'b11;
        @(negedge clk_clk);
        check("rstw_host_ack", host_ack, 1'b1);
        @(posedge clk_clk); #1;
        host_req = 1'b0;
        check("rstw_we_active", sram_WE_N, 1'b0);
        reset_reset_n = 1'b0;
        #1;
        check("rstw_pins_idle", {sram_CE_N, sram_OE_N, sram_WE_N, sram_LB_N, sram_UB_N}, 5'b11111);
        check("rstw_dq_released", (sram_DQ === 16'h9999), 1'b0);
        repeat (2) @(posedge clk_clk);
        #1 reset_reset_n = 1'b1;
        acks_after = 0; rv_after = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk_clk);
            if (vid_ack || host_ack) acks_after++;
            if (vid_rvalid || host_rvalid) rv_after++;
        end
        check("rstw_no_ack", acks_after, 0);
        check("rstw_no_rvalid", rv_after, 0);

        check("oe_we_overlap", overlap_cnt, 0);
        check("dual_ack", dual_ack_cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
